// File: rtl/deser_pkg.sv
// Shared definitions for the deserializer front end.
//   state_e     : arbiter FSM states.
//   DEF_NUM_CH  : default number of requesting channels.
//   DEF_IN_BW   : default beat width fed to the deserializer.
//   DEF_OUT_BW  : default completed frame width.
//   TAG_DEPTH   : depth of the frame-owner tag FIFO.
package deser_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam int unsigned DEF_NUM_CH = 4;
   localparam int unsigned DEF_IN_BW  = 32;
   localparam int unsigned DEF_OUT_BW = 512;
   localparam int unsigned TAG_DEPTH  = 2;

endpackage

// File: rtl/deser_tag_fifo.sv
// Small FIFO of channel IDs, one entry per frame granted but not yet emitted.
//   clk, reset_n  : clock, asynchronous active-low reset.
//   i_push        : write i_push_data (taken only when o_can_push).
//   i_pop         : drop the head entry (ignored when empty).
//   o_can_push    : room for a write this cycle, counting a same-cycle pop.
//   o_empty       : no entries held.
//   o_head        : oldest entry, forced to 0 when empty.
module deser_tag_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_can_push,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty    = (r_cnt == '0);
   assign w_full     = (r_cnt == CNT_W'(DEPTH));
   assign w_do_pop   = i_pop & ~o_empty;
   // When full, a write may land in the slot being vacated by the pop.
   assign o_can_push = ~w_full | w_do_pop;
   assign w_do_push  = i_push & o_can_push;
   assign o_head     = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= inc_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= inc_ptr(r_rd_ptr);
         if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
         else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/deser_arbiter.sv
// Round-robin arbiter feeding beats from NUM_CH channels into one deserializer.
// A grant holds one channel for exactly SEGS accepted beats (one frame); the
// owner ID of each granted frame is queued until the deserializer emits it.
//   clk, reset_n    : clock, asynchronous active-low reset.
//   ch_valid/data   : per-channel beat offer; ch_ready marks acceptance.
//   des_data_ready  : beat offered to the deserializer (des_data_in).
//   des_read_data   : deserializer takes the offered beat.
//   des_write_data  : deserializer emits a frame; pops the owner tag.
//   grant           : registered one-hot owner of the frame in progress.
//   tag_valid/chan  : owner of the oldest frame not yet emitted.
//   tag_err         : sticky, frame emitted with no tag pending.
module deser_arbiter import deser_pkg::*; #(
   parameter int unsigned  NUM_CH = DEF_NUM_CH,
   parameter int unsigned  IN_BW  = DEF_IN_BW,
   parameter int unsigned  OUT_BW = DEF_OUT_BW,
   localparam int unsigned SEGS   = OUT_BW / IN_BW,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CH-1:0]       ch_valid,
   input  logic [NUM_CH*IN_BW-1:0] ch_data,
   output logic [NUM_CH-1:0]       ch_ready,
   output logic                    des_data_ready,
   output logic [IN_BW-1:0]        des_data_in,
   input  logic                    des_read_data,
   input  logic                    des_write_data,
   output logic [NUM_CH-1:0]       grant,
   output logic                    tag_valid,
   output logic [CH_W-1:0]         tag_chan,
   output logic                    tag_err
);

   localparam int unsigned BC_W = (SEGS > 1) ? $clog2(SEGS) : 1;

   state_e            r_state,    w_state_nxt;
   logic [NUM_CH-1:0] r_grant,    w_grant_nxt;
   logic [CH_W-1:0]   r_gidx,     w_gidx_nxt;
   logic [BC_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
   logic [CH_W-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
   logic              r_tag_err;

   logic [CH_W-1:0]   w_cand [NUM_CH];
   logic              w_pick_found;
   logic [CH_W-1:0]   w_pick_idx;
   logic              w_beat_acc;
   logic              w_push;
   logic              w_can_push;
   logic              w_fifo_empty;

   // Candidates in priority order: the channel right after rr_ptr first.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         w_cand[k] = CH_W'((32'(r_rr_ptr) + k + 1) % NUM_CH);
         if (!w_pick_found && ch_valid[w_cand[k]]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand[k];
         end
      end
   end

   // Datapath mux: only the granted channel is visible, and only while BUSY.
   always_comb begin
      ch_ready       = '0;
      des_data_ready = 1'b0;
      des_data_in    = '0;
      if (r_state == BUSY) begin
         des_data_ready   = ch_valid[r_gidx];
         ch_ready[r_gidx] = des_read_data & ch_valid[r_gidx];
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (r_gidx == CH_W'(i)) des_data_in = ch_data[i*IN_BW +: IN_BW];
         end
      end
   end

   assign w_beat_acc = des_data_ready & des_read_data;

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_gidx_nxt     = r_gidx;
      w_beat_cnt_nxt = r_beat_cnt;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_push         = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_pick_found && w_can_push) begin
               w_state_nxt = BUSY;
               w_grant_nxt = NUM_CH'(1) << w_pick_idx;
               w_gidx_nxt  = w_pick_idx;
               w_push      = 1'b1;
            end
         end
         BUSY: begin
            if (w_beat_acc) begin
               if (r_beat_cnt == BC_W'(SEGS - 1)) begin
                  w_state_nxt    = IDLE;
                  w_grant_nxt    = '0;
                  w_beat_cnt_nxt = '0;
                  w_rr_ptr_nxt   = r_gidx;
               end else begin
                  w_beat_cnt_nxt = r_beat_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_gidx     <= '0;
         r_beat_cnt <= '0;
         r_rr_ptr   <= CH_W'(NUM_CH - 1);
         r_tag_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_gidx     <= w_gidx_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         if (des_write_data && w_fifo_empty) r_tag_err <= 1'b1;
      end
   end

   deser_tag_fifo #(
      .WIDTH (CH_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_push),
      .i_push_data (w_pick_idx),
      .i_pop       (des_write_data),
      .o_can_push  (w_can_push),
      .o_empty     (w_fifo_empty),
      .o_head      (tag_chan)
   );

   assign grant     = r_grant;
   assign tag_valid = ~w_fifo_empty;
   assign tag_err   = r_tag_err;

endmodule
